// File: rtl/ring_osc_meter_pkg.sv
// Shared types and default sizing for the ring-oscillator frequency meter.
package ring_osc_meter_pkg;

   localparam int CHANNELS_DEF    = 4;
   localparam int COUNT_W_DEF     = 32;
   localparam int TIME_W_DEF      = 32;
   localparam int SYNC_STAGES_DEF = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      STORE = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/ring_edge_sync.sv
// Per-channel synchroniser for an asynchronous ring-oscillator input,
// followed by a one-cycle rising-edge pulse generator.
module ring_edge_sync
   import ring_osc_meter_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic clk,
   input  logic reset_b,
   input  logic ring_in,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], ring_in};
      prev_d = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ring_osc_meter.sv
// Ring-oscillator meter: counts edges of one channel (or all channels in a
// sweep when RING_OSC_METER_SWEEP_EN is defined) over a timed window.
//
// state | meaning
// IDLE  | waiting for start
// COUNT | window timer running, counting edges of the current channel
// STORE | write count/overflow of the current channel into the bank
// DONE  | last measurement complete, waiting for start
module ring_osc_meter
   import ring_osc_meter_pkg::*;
#(
   parameter int  CHANNELS    = CHANNELS_DEF,
   parameter int  COUNT_W     = COUNT_W_DEF,
   parameter int  TIME_W      = TIME_W_DEF,
   parameter int  SYNC_STAGES = SYNC_STAGES_DEF,
   localparam int CH_W        = $clog2(CHANNELS)
) (
   input  logic               clk,
   input  logic               reset_b,
   input  logic [CHANNELS-1:0] ring_in,
   input  logic               start,
   input  logic               abort,
   input  logic               sweep,
   input  logic [CH_W-1:0]    channel_sel,
   input  logic [TIME_W-1:0]  integration_time,
   output logic               busy,
   output logic               done,
   input  logic [CH_W-1:0]    rd_sel,
   output logic [COUNT_W-1:0] rd_data,
   output logic               rd_overflow
);

   function automatic logic [CH_W-1:0] clamp_ch(input logic [CH_W-1:0] c);
      logic [CH_W-1:0] r;
      r = c;
      if (int'(c) > CHANNELS - 1) r = CH_W'(CHANNELS - 1);
      return r;
   endfunction

   logic [CHANNELS-1:0] rise;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_sync
      ring_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk     (clk),
         .reset_b (reset_b),
         .ring_in (ring_in[g]),
         .rise    (rise[g])
      );
   end

   state_e              state_q, state_d;
   logic [CH_W-1:0]     chan_q, chan_d;
   logic [TIME_W-1:0]   timer_q, timer_d;
   logic [COUNT_W-1:0]  count_q, count_d;
   logic                ovf_q, ovf_d;
   logic [COUNT_W-1:0]  bank_cnt_q [CHANNELS];
   logic [COUNT_W-1:0]  bank_cnt_d [CHANNELS];
   logic [CHANNELS-1:0] bank_ovf_q, bank_ovf_d;
`ifdef RING_OSC_METER_SWEEP_EN
   logic                sweep_q, sweep_d;
   logic [TIME_W-1:0]   time_q, time_d;
`else
   logic                sweep_unused;
   assign sweep_unused = sweep;
`endif

   always_comb begin
      state_d    = state_q;
      chan_d     = chan_q;
      timer_d    = timer_q;
      count_d    = count_q;
      ovf_d      = ovf_q;
      bank_cnt_d = bank_cnt_q;
      bank_ovf_d = bank_ovf_q;
`ifdef RING_OSC_METER_SWEEP_EN
      sweep_d    = sweep_q;
      time_d     = time_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (start && abort) begin
               state_d = IDLE;
            end else if (start) begin
`ifdef RING_OSC_METER_SWEEP_EN
               sweep_d = sweep;
               time_d  = integration_time;
               chan_d  = sweep ? '0 : clamp_ch(channel_sel);
`else
               chan_d  = clamp_ch(channel_sel);
`endif
               timer_d = integration_time;
               count_d = '0;
               ovf_d   = 1'b0;
               state_d = (integration_time == '0) ? STORE : COUNT;
            end
         end
         COUNT: begin
            if (abort) begin
               state_d = IDLE;
            end else begin
               if (rise[chan_q]) begin
                  if (&count_q) ovf_d = 1'b1;
                  else          count_d = count_q + 1'b1;
               end
               timer_d = timer_q - 1'b1;
               if (timer_q == TIME_W'(1)) state_d = STORE;
            end
         end
         STORE: begin
            if (abort) begin
               state_d = IDLE;
            end else begin
               bank_cnt_d[chan_q] = count_q;
               bank_ovf_d[chan_q] = ovf_q;
`ifdef RING_OSC_METER_SWEEP_EN
               if (sweep_q && (chan_q < CH_W'(CHANNELS - 1))) begin
                  chan_d  = chan_q + 1'b1;
                  timer_d = time_q;
                  count_d = '0;
                  ovf_d   = 1'b0;
                  state_d = (time_q == '0) ? STORE : COUNT;
               end else begin
                  state_d = DONE;
               end
`else
               state_d = DONE;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q    <= IDLE;
         chan_q     <= '0;
         timer_q    <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         bank_ovf_q <= '0;
         for (int i = 0; i < CHANNELS; i++) bank_cnt_q[i] <= '0;
`ifdef RING_OSC_METER_SWEEP_EN
         sweep_q    <= 1'b0;
         time_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         chan_q     <= chan_d;
         timer_q    <= timer_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         bank_ovf_q <= bank_ovf_d;
         bank_cnt_q <= bank_cnt_d;
`ifdef RING_OSC_METER_SWEEP_EN
         sweep_q    <= sweep_d;
         time_q     <= time_d;
`endif
      end
   end

   assign busy        = (state_q == COUNT) || (state_q == STORE);
   assign done        = (state_q == DONE);
   assign rd_data     = bank_cnt_q[clamp_ch(rd_sel)];
   assign rd_overflow = bank_ovf_q[clamp_ch(rd_sel)];

endmodule

// File: tb/tb_ring_osc_meter.sv
// Bench for ring_osc_meter: directed scenarios plus randomized runs scored
// against an edges-per-window model of the result bank.
module tb_ring_osc_meter;

   localparam int CH  = 4;
   localparam int CW  = 8;
   localparam int TW  = 32;
   localparam int CHW = 2;

   logic           clk = 1'b0;
   logic           reset_b = 1'b0;
   logic [CH-1:0]  ring_in = '0;
   logic           start = 1'b0;
   logic           abort = 1'b0;
   logic           sweep = 1'b0;
   logic [CHW-1:0] channel_sel = '0;
   logic [TW-1:0]  integration_time = '0;
   logic [CHW-1:0] rd_sel = '0;
   logic           busy, done, rd_overflow;
   logic [CW-1:0]  rd_data;

   ring_osc_meter #(
      .CHANNELS(CH), .COUNT_W(CW), .TIME_W(TW), .SYNC_STAGES(2)
   ) dut (
      .clk              (clk),
      .reset_b          (reset_b),
      .ring_in          (ring_in),
      .start            (start),
      .abort            (abort),
      .sweep            (sweep),
      .channel_sel      (channel_sel),
      .integration_time (integration_time),
      .busy             (busy),
      .done             (done),
      .rd_sel           (rd_sel),
      .rd_data          (rd_data),
      .rd_overflow      (rd_overflow)
   );

   always #5 clk = ~clk;

   // ring k toggles every half[k] clk cycles -> period 2*half[k]
   int half [CH] = '{4, 4, 4, 4};
   int ph   [CH] = '{0, 0, 0, 0};

   always @(negedge clk) begin
      for (int c = 0; c < CH; c++) begin
         if (ph[c] >= half[c] - 1) begin
            ph[c] = 0;
            ring_in[c] = ~ring_in[c];
         end else begin
            ph[c]++;
         end
      end
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input longint obs, input longint exp, input int tol = 0);
      n_checks++;
      if (obs >= exp - tol && obs <= exp + tol) n_pass++;
      else $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
   endtask

   // model of the bank: expected count, overflow and tolerance (-1 = not predictable)
   int exp_cnt [CH];
   bit exp_ovf [CH];
   int exp_tol [CH];

   function automatic bit sweep_enabled();
`ifdef RING_OSC_METER_SWEEP_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   function automatic void model_clear();
      for (int c = 0; c < CH; c++) begin
         exp_cnt[c] = 0; exp_ovf[c] = 1'b0; exp_tol[c] = 0;
      end
   endfunction

   function automatic bit ambiguous(input int c, input int n);
      int p = 2 * half[c];
      return (n > 255 * p) && (n < 256 * p);
   endfunction

   function automatic void model_store(input int c, input int n);
      int p = 2 * half[c];
      if (n >= 256 * p) begin
         exp_cnt[c] = 255; exp_ovf[c] = 1'b1; exp_tol[c] = 0;
      end else if (n <= 255 * p) begin
         exp_cnt[c] = n / p; exp_ovf[c] = 1'b0; exp_tol[c] = (n == 0) ? 0 : 1;
      end else begin
         exp_tol[c] = -1;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_bank(input string tag);
      for (int c = 0; c < CH; c++) begin
         rd_sel = c[CHW-1:0];
         #1;
         if (exp_tol[c] >= 0) begin
            check($sformatf("%s_cnt%0d", tag, c), rd_data, exp_cnt[c], exp_tol[c]);
            check($sformatf("%s_ovf%0d", tag, c), rd_overflow, exp_ovf[c]);
         end
      end
   endtask

   // one full measurement: latency from raising start to done, busy throughout
   task automatic run_meas(input string tag, input int ch, input bit sw, input int n);
      int lat, busy_low, k;
      bit eff;
      eff = sw && sweep_enabled();
      k = eff ? CH : 1;
      channel_sel = ch[CHW-1:0]; sweep = sw; integration_time = n; start = 1'b1;
      tick();
      start = 1'b0;
      lat = 1; busy_low = 0;
      while (!done && lat < 20000) begin
         if (!busy) busy_low++;
         tick();
         lat++;
      end
      if (eff) for (int c = 0; c < CH; c++) model_store(c, n);
      else     model_store(ch, n);
      check({tag, "_latency"}, lat, k * (n + 1) + 1);
      check({tag, "_busy_gap"}, busy_low, 0);
      check({tag, "_busy_end"}, busy, 0);
      check_bank(tag);
   endtask

   initial begin
      int lat, n, ch;
      bit sw, ok;

      model_clear();
      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check_bank("rst");
      reset_b = 1'b1;
      repeat (5) tick();

      // channel 2 at clk/8 for 800 cycles
      half = '{3, 5, 4, 6};
      run_meas("ch2", 2, 1'b0, 800);
      repeat (3) tick();
      check("done_level", done, 1);

      // all channels at clk/4, sweep requested
      half = '{2, 2, 2, 2};
      run_meas("sweep", 1, 1'b1, 400);

      // saturation with 8-bit counters
      run_meas("ovf", 3, 1'b0, 2000);

      // start and abort together in DONE: abort wins
      channel_sel = 2'd0; integration_time = 50; start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      check("sa_busy", busy, 0);
      check("sa_done", done, 0);
      tick();
      check("sa_busy2", busy, 0);

      // abort mid-measurement (channel 2 of a sweep when sweep is built in)
      half = '{4, 4, 4, 4};
      if (sweep_enabled()) begin
         channel_sel = 2'd0; sweep = 1'b1; integration_time = 160; start = 1'b1;
         tick();
         start = 1'b0;
         repeat (361) tick();
         model_store(0, 160);
         model_store(1, 160);
      end else begin
         channel_sel = 2'd2; sweep = 1'b0; integration_time = 300; start = 1'b1;
         tick();
         start = 1'b0;
         repeat (100) tick();
      end
      check("abort_busy_pre", busy, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      repeat (3) tick();
      check("abort_idle", busy | done, 0);
      check_bank("abort");

      // zero-length window
      run_meas("zero", 1, 1'b0, 0);

      // start while busy is ignored
      half = '{3, 3, 3, 3};
      channel_sel = 2'd0; sweep = 1'b0; integration_time = 200; start = 1'b1;
      tick();
      start = 1'b0;
      lat = 1;
      repeat (49) begin tick(); lat++; end
      channel_sel = 2'd3; integration_time = 5; start = 1'b1;
      tick(); lat++;
      start = 1'b0;
      while (!done && lat < 20000) begin tick(); lat++; end
      model_store(0, 200);
      check("ign_latency", lat, 202);
      check_bank("ign");

      // randomized runs
      for (int it = 0; it < 8; it++) begin
         for (int c = 0; c < CH; c++) half[c] = $urandom_range(1, 6);
         ch = $urandom_range(0, CH - 1);
         sw = 1'($urandom_range(0, 1));
         for (int t = 0; t < 50; t++) begin
            n = $urandom_range(0, 700);
            ok = 1'b1;
            for (int c = 0; c < CH; c++) if (ambiguous(c, n)) ok = 1'b0;
            if (ok) break;
         end
         run_meas($sformatf("rnd%0d", it), ch, sw, n);
      end

      // reset in the middle of a window
      half = '{2, 3, 4, 5};
      channel_sel = 2'd1; sweep = 1'b0; integration_time = 300; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (100) tick();
      check("mid_busy_pre", busy, 1);
      reset_b = 1'b0;
      #1;
      model_clear();
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check_bank("mid_rst");
      tick();
      reset_b = 1'b1;
      repeat (3) tick();
      check("post_rst_idle", busy | done, 0);
      check_bank("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ring_osc_meter.md
RING_OSC_METER -- requirements
Module: ring_osc_meter

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, giving the number of ring-oscillator inputs (2..16).
REQ-002 The block SHALL have parameter COUNT_W, default 32, giving the edge counter and result width.
REQ-003 The block SHALL have parameter TIME_W, default 32, giving the integration timer width.
REQ-004 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchroniser depth per ring input (min 2).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port reset_b, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port ring_in, input, CHANNELS bits: asynchronous oscillator (or pre-divided) signals.
REQ-008 The block SHALL have port start, input, 1 bit: measurement request.
REQ-009 The block SHALL have port abort, input, 1 bit: cancel the running measurement.
REQ-010 The block SHALL have port sweep, input, 1 bit: measure all channels in sequence; sampled on start.
REQ-011 The block SHALL have port channel_sel, input, CH_W=$clog2(CHANNELS) bits: single-channel target; sampled on start.
REQ-012 The block SHALL have port integration_time, input, TIME_W bits: window length in clk cycles; sampled on start.
REQ-013 The block SHALL have port busy, output, 1 bit: a measurement is in progress.
REQ-014 The block SHALL have port done, output, 1 bit: the last measurement completed; level.
REQ-015 The block SHALL have port rd_sel, input, CH_W bits: result bank read address.
REQ-016 The block SHALL have port rd_data, output, COUNT_W bits: stored count for rd_sel; combinational read.
REQ-017 The block SHALL have port rd_overflow, output, 1 bit: stored overflow flag for rd_sel.

Function
REQ-018 The block SHALL synchronise each ring_in bit through SYNC_STAGES flops and SHALL detect rising edges per channel every cycle, independent of FSM state.
REQ-019 The FSM SHALL have states IDLE, COUNT, STORE, DONE.
REQ-020 start SHALL be accepted in IDLE or DONE; in any other state it SHALL be ignored.
REQ-021 On accepted start the block SHALL latch sweep, channel_sel (channel 0 if sweep) and integration_time, clear the edge counter, load the timer, and enter COUNT on the next cycle.
REQ-022 COUNT SHALL last exactly integration_time cycles, counting rising edges of the selected channel detected in those cycles.
REQ-023 An integration_time of 0 SHALL skip COUNT: a count of 0 is stored.
REQ-024 The edge counter SHALL saturate at all-ones; any edge at saturation SHALL set the measurement's overflow flag.
REQ-025 STORE SHALL last one cycle and write count and overflow into the bank entry of the current channel.
REQ-026 From STORE, if sweep and channel < CHANNELS-1, the block SHALL increment the channel, reload the timer, clear the counter, and return to COUNT; otherwise it SHALL go to DONE.
REQ-027 busy SHALL be 1 in COUNT and STORE and 0 otherwise; done SHALL be 1 only in DONE.
REQ-028 abort in COUNT or STORE SHALL return the FSM to IDLE next cycle without writing the current channel; entries already written in the sweep are kept.
REQ-029 If abort and start are both high in IDLE/DONE, abort SHALL win: the block goes to or stays in IDLE.
REQ-030 A channel_sel >= CHANNELS SHALL be clamped to CHANNELS-1.

Reset
REQ-031 While reset_b=0 the FSM SHALL be IDLE, busy=0, done=0, and all counters, timer, synchronisers, bank counts and overflow flags SHALL be 0.
REQ-032 Reset asserted mid-measurement SHALL abort it immediately; rd_data then reads 0 for every channel.

Configuration
REQ-033 Macro RING_OSC_METER_SWEEP_EN SHALL control sweep support.
REQ-034 With RING_OSC_METER_SWEEP_EN defined, sweep SHALL behave as in REQ-026.
REQ-035 Without RING_OSC_METER_SWEEP_EN, the sweep input SHALL be ignored, every start SHALL measure one channel, and the channel-increment logic SHALL be absent.

Structure
REQ-036 A shared package ring_osc_meter_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-037 The per-channel synchroniser plus edge detector SHALL be a sub-module, ring_edge_sync, instantiated CHANNELS times.

Verification
REQ-038 A bench SHALL cover the following scenarios.
- Channel 2 at clk/8, integration_time=800, start, no sweep -> done after 802 cycles, bank[2]=100±1, overflow 0.
- Sweep with all channels at clk/4, integration_time=400 -> four STOREs, bank[0..3]=100±1 each, done once.
- COUNT_W=8, channel at clk/4, integration_time=2000 -> bank entry 255, rd_overflow 1.
- abort during channel 2 of a sweep -> IDLE, bank[0..1] written, bank[2..3] unchanged, done 0.
- integration_time=0 -> bank entry 0, done 2 cycles after start; start while busy -> ignored.
- reset_b pulsed low mid-COUNT -> busy, done and all bank entries 0 immediately.
